// File: rtl/issue_scoreboard.sv
// Issue-stage register scoreboard: per-GPR and EFLAGS write-back countdowns gate micro-op issue.
// Optional macro SCOREBOARD_FWD_EN: results due within one cycle are bypassed and do not stall.
module issue_scoreboard #(
    parameter int LAT_ALU  = 1,
    parameter int LAT_LOAD = 3
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        id_valid,
    input  logic        id_d_from_gpr,
    input  logic        id_d_to_gpr,
    input  logic        id_s_from_gpr,
    input  logic        id_t_from_gpr,
    input  logic        id_from_eflags,
    input  logic        id_to_eflags,
    input  logic [3:0]  id_rd,
    input  logic [3:0]  id_rs,
    input  logic [3:0]  id_rt,
    input  logic        id_is_load,
    input  logic        ex_ready,
    input  logic        flush,
    output logic        issue,
    output logic        stall,
    output logic [15:0] gpr_busy,
    output logic        eflags_busy
);

    localparam logic [1:0] LAT_ALU_C  = 2'(LAT_ALU);
    localparam logic [1:0] LAT_LOAD_C = 2'(LAT_LOAD);

    // A countdown blocks a reader only while its result cannot yet reach the operand.
    function automatic logic is_hot(input logic [1:0] cnt);
`ifdef SCOREBOARD_FWD_EN
        return cnt > 2'd1;
`else
        return cnt != 2'd0;
`endif
    endfunction

    logic [15:0] gpr_hz;
    logic        flags_hz;
    logic        hazard;
    logic [1:0]  wr_lat;
    logic [1:0]  flags_cnt_reg;
    logic [1:0]  flags_cnt_next;
    logic [1:0]  flags_dec;

    assign wr_lat = id_is_load ? LAT_LOAD_C : LAT_ALU_C;

    // Hazard is evaluated on the pre-issue countdowns, so rd==rs micro-ops see the old writer.
    assign hazard = (id_d_from_gpr  & gpr_hz[id_rd])
                  | (id_s_from_gpr  & gpr_hz[id_rs])
                  | (id_t_from_gpr  & gpr_hz[id_rt])
                  | (id_from_eflags & flags_hz);

    assign issue = id_valid & ex_ready & ~hazard & ~flush;
    assign stall = id_valid & hazard & ~flush;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_gpr
            logic [1:0] cnt_reg;
            logic [1:0] cnt_next;
            logic [1:0] dec_val;
            logic       wr_hit;

            assign dec_val = (cnt_reg != 2'd0) ? cnt_reg - 2'd1 : 2'd0;
            assign wr_hit  = issue & id_d_to_gpr & (id_rd == 4'(gi));

            always_comb begin
                cnt_next = dec_val;
                if (wr_hit && (wr_lat > dec_val)) begin
                    cnt_next = wr_lat;
                end
                if (flush) begin
                    cnt_next = 2'd0;
                end
            end

            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    cnt_reg <= 2'd0;
                end else begin
                    cnt_reg <= cnt_next;
                end
            end

            assign gpr_busy[gi] = (cnt_reg != 2'd0);
            assign gpr_hz[gi]   = is_hot(cnt_reg);
        end
    endgenerate

    assign flags_dec = (flags_cnt_reg != 2'd0) ? flags_cnt_reg - 2'd1 : 2'd0;

    always_comb begin
        flags_cnt_next = flags_dec;
        if (issue && id_to_eflags && (LAT_ALU_C > flags_dec)) begin
            flags_cnt_next = LAT_ALU_C;
        end
        if (flush) begin
            flags_cnt_next = 2'd0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            flags_cnt_reg <= 2'd0;
        end else begin
            flags_cnt_reg <= flags_cnt_next;
        end
    end

    assign flags_hz    = is_hot(flags_cnt_reg);
    assign eflags_busy = (flags_cnt_reg != 2'd0);

endmodule
